// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared widths, opcode encoding and arbiter FSM states for the ALU arbiter
// slice (alu_arbiter and its ALU sub-module).
//   DATA_W  : operand / result width
//   OP_W    : opcode width
//   OVF_W   : overflow flag width ({signed overflow, carry out})
//   NUM_REQ : number of requesters served by the arbiter
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 3;
    localparam int OVF_W   = 2;
    localparam int NUM_REQ = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'b000,
        OP_XOR = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_ADD = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Opcodes above ADD have no ALU function and are flagged as errors.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op > OP_ADD);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational 8-bit ALU shared by the arbiter.
// Ports:
//   op       in  OP_W    opcode (AND, XOR, SHL, SHR, ADD; others -> default)
//   r1       in  DATA_W  first operand; shift amount for SHL/SHR
//   r2       in  DATA_W  second operand; value being shifted for SHL/SHR
//   out      out DATA_W  result (0 for undefined opcodes)
//   overflow out OVF_W   {signed overflow, carry out}, ADD only, else 0
//   zf       out 1       result is zero
// ---------------------------------------------------------------------------
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] out,
    output logic [OVF_W-1:0]  overflow,
    output logic              zf
);

    logic [DATA_W:0] sum;
    logic            signed_ovf;

    assign sum = {1'b0, r1} + {1'b0, r2};
    // Two same-sign operands producing a result of the other sign.
    assign signed_ovf = (r1[DATA_W-1] == r2[DATA_W-1]) &&
                        (sum[DATA_W-1] != r1[DATA_W-1]);

    always_comb begin
        out      = '0;
        overflow = '0;
        case (op)
            OP_AND: out = r1 & r2;
            OP_XOR: out = r1 ^ r2;
            // Shift amounts of DATA_W or more clear the result.
            OP_SHL: out = r2 << r1;
            OP_SHR: out = r2 >> r1;
            OP_ADD: begin
                out      = sum[DATA_W-1:0];
                overflow = {signed_ovf, sum[DATA_W]};
            end
            default: begin
                out      = '0;
                overflow = '0;
            end
        endcase
    end

    assign zf = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Two-requester front end to one shared ALU. One operation is in flight at a
// time: IDLE accepts a request, EXEC evaluates it from the operand registers,
// RESP holds the result until the owning requester takes it.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   reqN_valid/ready        request handshake for requester N (N = 0, 1)
//   reqN_op, reqN_r1/r2     opcode and operands of requester N
//   rspN_valid/ready        response handshake for requester N
//   rsp_data/ovf/zf/err     shared result bus, qualified by rspN_valid
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN   defined: requester 0 always wins a tie and no
//                           last-grant state exists; undefined: round-robin.
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_r1,
    input  logic [DATA_W-1:0] req0_r2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_r1,
    input  logic [DATA_W-1:0] req1_r2,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [OVF_W-1:0]  rsp_ovf,
    output logic              rsp_zf,
    output logic              rsp_err
);

    // Requester ports gathered into vectors so per-requester logic is uniform.
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_ready_vec;
    logic [OP_W-1:0]    req_op [NUM_REQ];
    logic [DATA_W-1:0]  req_r1 [NUM_REQ];
    logic [DATA_W-1:0]  req_r2 [NUM_REQ];

    assign req_valid     = {req1_valid, req0_valid};
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};
    assign req_op[0]     = req0_op;
    assign req_op[1]     = req1_op;
    assign req_r1[0]     = req0_r1;
    assign req_r1[1]     = req1_r1;
    assign req_r2[0]     = req0_r2;
    assign req_r2[1]     = req1_r2;

    arb_state_e         state_reg;
    logic               owner_reg;
    logic [OP_W-1:0]    op_reg;
    logic [DATA_W-1:0]  r1_reg;
    logic [DATA_W-1:0]  r2_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [OVF_W-1:0]   ovf_reg;
    logic               zf_reg;
    logic               err_reg;
    logic [NUM_REQ-1:0] rsp_valid_reg;

    logic               grant_id;
    logic               accept;

    logic [DATA_W-1:0]  alu_out;
    logic [OVF_W-1:0]   alu_ovf;
    logic               alu_zf;

    // ------------------------------------------------------------------
    // Grant selection: a lone valid requester wins; a tie is resolved by
    // fixed priority or by alternating away from the last granted one.
    // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant_id = req_valid[1] & ~req_valid[0];
`else
    logic last_gnt_reg;

    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_id = ~last_gnt_reg;
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_reg <= 1'b1;
        end else if (accept) begin
            last_gnt_reg <= grant_id;
        end
    end
`endif

    // READY must follow VALID within the same cycle, so it is decoded from
    // the registered state rather than registered itself.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_ready[gi] = (state_reg == ST_IDLE) && req_valid[gi] &&
                                   (grant_id == 1'(gi));
        end
    endgenerate

    assign accept = |req_ready;

    // ------------------------------------------------------------------
    // FSM plus operand / result registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= 1'b0;
            op_reg        <= '0;
            r1_reg        <= '0;
            r2_reg        <= '0;
            data_reg      <= '0;
            ovf_reg       <= '0;
            zf_reg        <= 1'b0;
            err_reg       <= 1'b0;
            rsp_valid_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        owner_reg <= grant_id;
                        op_reg    <= req_op[grant_id];
                        r1_reg    <= req_r1[grant_id];
                        r2_reg    <= req_r2[grant_id];
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    data_reg      <= alu_out;
                    ovf_reg       <= alu_ovf;
                    zf_reg        <= alu_zf;
                    err_reg       <= op_is_illegal(op_reg);
                    rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
                    state_reg     <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's VALID is high, so the AND ignores the
                    // other requester's READY.
                    if (|(rsp_valid_reg & rsp_ready_vec)) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= '0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    // The ALU sees only the operand registers, isolating it from requester
    // inputs that change after acceptance.
    alu_arbiter_alu u_alu (
        .op       (op_reg),
        .r1       (r1_reg),
        .r2       (r2_reg),
        .out      (alu_out),
        .overflow (alu_ovf),
        .zf       (alu_zf)
    );

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp_data   = data_reg;
    assign rsp_ovf    = ovf_reg;
    assign rsp_zf     = zf_reg;
    assign rsp_err    = err_reg;

endmodule
